// File: rtl/timecode_sequencer.sv
// Timecode sequencer: keeps an hours:minutes:seconds:frames time value,
// captures its 80-bit LTC word from an external encoder and sends it
// LSB first as a biphase-mark serial stream, advancing the time after
// each transmitted frame.
module timecode_sequencer #(
    parameter int FPS = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        half_tick,
    input  logic        preset_valid,
    output logic        preset_ready,
    input  logic [3:0]  preset_hours,
    input  logic [6:0]  preset_minutes,
    input  logic [6:0]  preset_seconds,
    input  logic [23:0] preset_frames,
    output logic [3:0]  enc_hours,
    output logic [6:0]  enc_minutes,
    output logic [6:0]  enc_seconds,
    output logic [23:0] enc_frames,
    input  logic [79:0] enc_timecode,
    output logic        ltc_out,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_e;

    localparam logic [23:0] FRAME_LIMIT = 24'(FPS);
    localparam logic [23:0] FRAME_LAST  = 24'(FPS - 1);

    state_e      state_q, state_d;
    logic [79:0] shift_q;
    logic [6:0]  bit_idx_q;
    logic        half_sel_q;
    logic        ltc_q;
    logic        frame_done_q;
    logic [3:0]  hours_q;
    logic [6:0]  minutes_q;
    logic [6:0]  seconds_q;
    logic [23:0] frames_q;

    logic presetXfer;
    logic frameEnd;

    assign presetXfer = preset_valid && (state_q == IDLE);
    assign frameEnd   = (state_q == SHIFT) && half_tick && half_sel_q
                        && (bit_idx_q == 7'd79);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a preset in IDLE wins over run for that cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!presetXfer && run) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (frameEnd) state_d = run ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded handshake and status outputs.
    always_comb begin
        preset_ready = (state_q == IDLE);
        busy         = (state_q == LOAD) || (state_q == SHIFT);
    end

    // Serialiser: capture in LOAD, biphase-mark toggling on half ticks in SHIFT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q      <= '0;
            bit_idx_q    <= '0;
            half_sel_q   <= 1'b0;
            ltc_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frameEnd;
            if (state_q == LOAD) begin
                shift_q    <= enc_timecode;
                bit_idx_q  <= '0;
                half_sel_q <= 1'b0;
            end else if (state_q == SHIFT && half_tick) begin
                if (!half_sel_q) begin
                    ltc_q      <= ~ltc_q;
                    half_sel_q <= 1'b1;
                end else begin
                    if (shift_q[0]) begin
                        ltc_q <= ~ltc_q;
                    end
                    half_sel_q <= 1'b0;
                    shift_q    <= {1'b0, shift_q[79:1]};
                    bit_idx_q  <= bit_idx_q + 7'd1;
                end
            end
        end
    end

    // Time registers: clamped preset load in IDLE, carry-chain increment at frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hours_q   <= '0;
            minutes_q <= '0;
            seconds_q <= '0;
            frames_q  <= '0;
        end else if (presetXfer) begin
            hours_q   <= preset_hours;
            minutes_q <= (preset_minutes > 7'd59) ? 7'd0 : preset_minutes;
            seconds_q <= (preset_seconds > 7'd59) ? 7'd0 : preset_seconds;
            frames_q  <= (preset_frames >= FRAME_LIMIT) ? 24'd0 : preset_frames;
        end else if (frameEnd) begin
            if (frames_q == FRAME_LAST) begin
                frames_q <= '0;
                if (seconds_q == 7'd59) begin
                    seconds_q <= '0;
                    if (minutes_q == 7'd59) begin
                        minutes_q <= '0;
                        hours_q   <= hours_q + 4'd1;
                    end else begin
                        minutes_q <= minutes_q + 7'd1;
                    end
                end else begin
                    seconds_q <= seconds_q + 7'd1;
                end
            end else begin
                frames_q <= frames_q + 24'd1;
            end
        end
    end

    assign enc_hours   = hours_q;
    assign enc_minutes = minutes_q;
    assign enc_seconds = seconds_q;
    assign enc_frames  = frames_q;
    assign ltc_out     = ltc_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_timecode_sequencer.sv
// Bench for timecode_sequencer: table-driven preset vectors plus frame
// sequences checked through a scoreboard of expected transition counts
// and post-frame time values.
module tb_timecode_sequencer;

    localparam int FPS = 25;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        half_tick = 1'b0;
    logic        preset_valid = 1'b0;
    logic        preset_ready;
    logic [3:0]  preset_hours = '0;
    logic [6:0]  preset_minutes = '0;
    logic [6:0]  preset_seconds = '0;
    logic [23:0] preset_frames = '0;
    logic [3:0]  enc_hours;
    logic [6:0]  enc_minutes;
    logic [6:0]  enc_seconds;
    logic [23:0] enc_frames;
    logic [79:0] enc_timecode;
    logic        ltc_out;
    logic        busy;
    logic        frame_done;

    logic        stubMode = 1'b0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          trans;
        logic [3:0]  h;
        logic [6:0]  m;
        logic [6:0]  s;
        logic [23:0] f;
    } sbEntry_t;

    typedef struct {
        logic [3:0]  h;
        logic [6:0]  m;
        logic [6:0]  s;
        logic [23:0] f;
        logic [3:0]  eh;
        logic [6:0]  em;
        logic [6:0]  es;
        logic [23:0] ef;
    } presetVec_t;

    sbEntry_t sb[$];
    sbEntry_t popped;

    // Bench-side model of the time value the DUT should hold.
    logic [3:0]  mh = '0;
    logic [6:0]  mm = '0;
    logic [6:0]  ms = '0;
    logic [23:0] mf = '0;

    int  transCount = 0;
    int  frameCount = 0;
    logic prevLtc = 1'b0;

    timecode_sequencer #(.FPS(FPS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .half_tick      (half_tick),
        .preset_valid   (preset_valid),
        .preset_ready   (preset_ready),
        .preset_hours   (preset_hours),
        .preset_minutes (preset_minutes),
        .preset_seconds (preset_seconds),
        .preset_frames  (preset_frames),
        .enc_hours      (enc_hours),
        .enc_minutes    (enc_minutes),
        .enc_seconds    (enc_seconds),
        .enc_frames     (enc_frames),
        .enc_timecode   (enc_timecode),
        .ltc_out        (ltc_out),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    // Encoder stub: time fields packed above a fixed filler pattern.
    function automatic logic [79:0] stubWord(input logic [3:0] h, input logic [6:0] m,
                                             input logic [6:0] s, input logic [23:0] f);
        return {f, s, m, h, 38'h25A5A5A5A5};
    endfunction

    assign enc_timecode = stubMode ? 80'h1 : stubWord(enc_hours, enc_minutes, enc_seconds, enc_frames);

    always #5 clk = ~clk;

    // Free-running half-tick strobe, one cycle high every four.
    initial begin : halfTickGen
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            cnt++;
            half_tick = (cnt % 4 == 0);
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic pv, input logic [3:0] h, input logic [6:0] m,
                                 input logic [6:0] s, input logic [23:0] f, input logic r);
        preset_valid   = pv;
        preset_hours   = h;
        preset_minutes = m;
        preset_seconds = s;
        preset_frames  = f;
        run            = r;
        step();
    endtask

    task automatic doPreset(input logic [3:0] h, input logic [6:0] m, input logic [6:0] s, input logic [23:0] f);
        applyStimulus(1'b1, h, m, s, f, 1'b0);
        preset_valid = 1'b0;
        mh = h; mm = m; ms = s; mf = f;
    endtask

    // Advance the model time by one frame.
    task automatic incTime();
        if (mf == 24'(FPS - 1)) begin
            mf = 0;
            if (ms == 7'd59) begin
                ms = 0;
                if (mm == 7'd59) begin
                    mm = 0;
                    mh = mh + 4'd1;
                end else mm = mm + 7'd1;
            end else ms = ms + 7'd1;
        end else mf = mf + 24'd1;
    endtask

    // Push the expectation for one frame captured from the current model time.
    task automatic expectFrame();
        sbEntry_t e;
        logic [79:0] w;
        w = stubMode ? 80'h1 : stubWord(mh, mm, ms, mf);
        e.trans = 80 + $countones(w);
        incTime();
        e.h = mh; e.m = mm; e.s = ms; e.f = mf;
        sb.push_back(e);
    endtask

    task automatic waitFrameDone(input int maxCycles);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < maxCycles) begin
            step();
            n++;
        end
        if (frame_done !== 1'b1) begin
            tests++;
            fails++;
            $display("[TB] FAIL frame_done timeout: got 0, expected 1");
        end
    endtask

    task automatic oneFrame();
        expectFrame();
        run = 1'b1;
        step();
        checkOutput("busy in LOAD", busy, 1);
        run = 1'b0;
        waitFrameDone(800);
        step();
        checkOutput("busy after frame", busy, 0);
        checkOutput("preset_ready after frame", preset_ready, 1);
    endtask

    // Monitor: counts ltc_out transitions and scores each frame_done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            transCount = 0;
            prevLtc = ltc_out;
        end else begin
            if (ltc_out !== prevLtc) transCount++;
            prevLtc = ltc_out;
            if (frame_done === 1'b1) begin
                frameCount++;
                if (sb.size() == 0) begin
                    checkOutput("unexpected frame_done", 1, 0);
                end else begin
                    popped = sb.pop_front();
                    checkOutput("ltc transitions", transCount, popped.trans);
                    checkOutput("post-frame enc_hours", enc_hours, popped.h);
                    checkOutput("post-frame enc_minutes", enc_minutes, popped.m);
                    checkOutput("post-frame enc_seconds", enc_seconds, popped.s);
                    checkOutput("post-frame enc_frames", enc_frames, popped.f);
                end
                transCount = 0;
            end
        end
    end

    // Main test sequence.
    initial begin : mainSeq
        presetVec_t vecs[5];
        int framesBefore;

        vecs[0] = '{4'd1,  7'd2,  7'd3,  24'd4,  4'd1,  7'd2,  7'd3,  24'd4};
        vecs[1] = '{4'd0,  7'd61, 7'd75, 24'd30, 4'd0,  7'd0,  7'd0,  24'd0};
        vecs[2] = '{4'd15, 7'd59, 7'd59, 24'd24, 4'd15, 7'd59, 7'd59, 24'd24};
        vecs[3] = '{4'd5,  7'd59, 7'd60, 24'd25, 4'd5,  7'd59, 7'd0,  24'd0};
        vecs[4] = '{4'd3,  7'd60, 7'd10, 24'd23, 4'd3,  7'd0,  7'd10, 24'd23};

        // Reset values.
        step();
        step();
        checkOutput("reset ltc_out", ltc_out, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset frame_done", frame_done, 0);
        checkOutput("reset preset_ready", preset_ready, 1);
        checkOutput("reset enc_hours", enc_hours, 0);
        checkOutput("reset enc_minutes", enc_minutes, 0);
        checkOutput("reset enc_seconds", enc_seconds, 0);
        checkOutput("reset enc_frames", enc_frames, 0);
        rst_n = 1'b1;
        step();

        // Preset vectors including out-of-range clamping.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].f, 1'b0);
            checkOutput("preset enc_hours", enc_hours, vecs[i].eh);
            checkOutput("preset enc_minutes", enc_minutes, vecs[i].em);
            checkOutput("preset enc_seconds", enc_seconds, vecs[i].es);
            checkOutput("preset enc_frames", enc_frames, vecs[i].ef);
            checkOutput("preset_ready idle", preset_ready, 1);
        end
        preset_valid = 1'b0;
        step();

        // Single frame with constant encoder word 80'h1.
        stubMode = 1'b1;
        doPreset(4'd1, 7'd2, 7'd3, 24'd4);
        oneFrame();
        checkOutput("enc_frames after first frame", enc_frames, 5);
        stubMode = 1'b0;

        // Full wrap of the time value.
        doPreset(4'd15, 7'd59, 7'd59, 24'd24);
        oneFrame();
        checkOutput("wrap enc_hours", enc_hours, 0);
        checkOutput("wrap enc_frames", enc_frames, 0);

        // Run dropped around bit 40: frame still completes, only once.
        doPreset(4'd10, 7'd20, 7'd30, 24'd12);
        expectFrame();
        run = 1'b1;
        step();
        repeat (330) step();
        run = 1'b0;
        checkOutput("busy mid-frame", busy, 1);
        waitFrameDone(800);
        step();
        framesBefore = frameCount;
        repeat (700) step();
        checkOutput("no extra frame after run drop", frameCount, framesBefore);
        checkOutput("busy idle after drop", busy, 0);
        checkOutput("preset_ready idle after drop", preset_ready, 1);

        // Back-to-back frames: the second captures the incremented time.
        doPreset(4'd0, 7'd0, 7'd59, 24'd24);
        expectFrame();
        expectFrame();
        run = 1'b1;
        step();
        waitFrameDone(800);
        step();
        checkOutput("busy between frames", busy, 1);
        run = 1'b0;
        waitFrameDone(800);
        step();
        checkOutput("busy after two frames", busy, 0);

        // Preset held while busy, accepted on first IDLE cycle; run delays LOAD.
        doPreset(4'd2, 7'd0, 7'd0, 24'd0);
        expectFrame();
        run = 1'b1;
        step();
        run = 1'b0;
        preset_valid = 1'b1;
        preset_hours = 4'd7; preset_minutes = 7'd7; preset_seconds = 7'd7; preset_frames = 24'd7;
        repeat (100) step();
        checkOutput("preset_ready while busy", preset_ready, 0);
        checkOutput("enc_hours held while busy", enc_hours, 2);
        checkOutput("enc_frames held while busy", enc_frames, 0);
        waitFrameDone(800);
        checkOutput("enc_frames before preset accept", enc_frames, 1);
        run = 1'b1;
        step();
        checkOutput("stay idle on preset+run", preset_ready, 1);
        checkOutput("not busy on preset+run", busy, 0);
        checkOutput("accepted enc_hours", enc_hours, 7);
        checkOutput("accepted enc_minutes", enc_minutes, 7);
        checkOutput("accepted enc_seconds", enc_seconds, 7);
        checkOutput("accepted enc_frames", enc_frames, 7);
        preset_valid = 1'b0;
        mh = 4'd7; mm = 7'd7; ms = 7'd7; mf = 24'd7;
        expectFrame();
        step();
        checkOutput("LOAD after preset", busy, 1);
        run = 1'b0;
        waitFrameDone(800);
        step();

        // Asynchronous reset around bit 30 aborts the frame.
        doPreset(4'd3, 7'd3, 7'd3, 24'd3);
        run = 1'b1;
        step();
        run = 1'b0;
        repeat (245) step();
        checkOutput("busy before reset", busy, 1);
        framesBefore = frameCount;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset ltc_out", ltc_out, 0);
        checkOutput("async reset busy", busy, 0);
        checkOutput("async reset frame_done", frame_done, 0);
        checkOutput("async reset preset_ready", preset_ready, 1);
        checkOutput("async reset enc_hours", enc_hours, 0);
        checkOutput("async reset enc_minutes", enc_minutes, 0);
        checkOutput("async reset enc_seconds", enc_seconds, 0);
        checkOutput("async reset enc_frames", enc_frames, 0);
        mh = '0; mm = '0; ms = '0; mf = '0;
        step();
        step();
        rst_n = 1'b1;
        repeat (700) step();
        checkOutput("no frame_done after abort", frameCount, framesBefore);
        checkOutput("idle after reset release", preset_ready, 1);

        checkOutput("scoreboard drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/timecode_sequencer.md
TIMECODE_SEQUENCER -- requirements
Module: timecode_sequencer

Interface
REQ-001 Parameter FPS, default 25, frames per second; legal values 24, 25, 30.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 run  input  1  level enable; while 1, frames are generated back to back.
REQ-005 half_tick  input  1  one-cycle strobe at twice the LTC bit rate; spacing of at least 3 clk cycles.
REQ-006 preset_valid  input  1  preset request.
REQ-007 preset_ready  output  1  preset accept; equals 1 exactly when the FSM is in IDLE.
REQ-008 preset_hours/minutes/seconds/frames  input  4/7/7/24  preset time value.
REQ-009 enc_hours/enc_minutes/enc_seconds/enc_frames  output  4/7/7/24  drive the timecode encoder inputs directly from the internal time registers.
REQ-010 enc_timecode  input  80  encoder result, combinational from the enc_* outputs.
REQ-011 ltc_out  output  1  biphase-mark serial LTC.
REQ-012 busy  output  1  1 in LOAD or SHIFT.
REQ-013 frame_done  output  1  one-cycle pulse at the end of each transmitted frame.

Function
REQ-014 The FSM SHALL have the states IDLE, LOAD and SHIFT.
REQ-015 IDLE -> LOAD on the cycle after run=1 when no preset transfer occurs in the same cycle.
REQ-016 LOAD SHALL last exactly one cycle, capture enc_timecode into an 80-bit shift register, clear bit_idx (7 bits) and half_sel, and go to SHIFT.
REQ-017 SHIFT SHALL act only on half_tick; the first half_tick of a bit toggles ltc_out and the second toggles ltc_out only if the current bit is 1.
REQ-018 Bits SHALL be sent LSB first (timecode bit 0 first), with bit_idx advancing after the second half_tick of each bit.
REQ-019 After the second half of bit 79: pulse frame_done for one cycle, increment the time registers, then go to LOAD if run=1, otherwise to IDLE.
REQ-020 Increment order: frames FPS-1->0 carries to seconds, seconds 59->0 carries to minutes, minutes 59->0 carries to hours, hours 15->0 wraps.
REQ-021 The LOAD that follows a frame SHALL capture the timecode of the incremented time (one-cycle latency from register to capture via the encoder).
REQ-022 A preset transfer occurs on preset_valid && preset_ready; each field loads its time register, and any field out of range (frames>=FPS, seconds>59, minutes>59) loads 0.
REQ-023 Preset and run in the same IDLE cycle: the preset takes priority, the FSM stays in IDLE that cycle, and LOAD follows the next cycle if run is still 1.
REQ-024 Deasserting run mid-frame SHALL NOT truncate the frame; all 80 bits complete, then IDLE.
REQ-025 preset_valid while busy SHALL be ignored (no register change) until IDLE.
REQ-026 In IDLE and LOAD, ltc_out SHALL hold its level; half_tick in those states is ignored.
REQ-027 Each frame SHALL produce 80 + popcount(captured word) ltc_out transitions.

Reset
REQ-028 With rst_n=0, immediately and independent of clk: state=IDLE, ltc_out=0, busy=0, frame_done=0, preset_ready=1, all enc_* = 0, shift register, bit_idx and half_sel = 0.
REQ-029 Reset mid-frame SHALL abort the frame with no frame_done pulse; operation resumes from IDLE after rst_n rises.

Verification
REQ-030 Reset: assert rst_n=0 mid-SHIFT at bit 30 -> all outputs reach the REQ-028 values without a clk edge; no frame_done.
REQ-031 Preset 01:02:03:04 then run=1, encoder stub enc_timecode=80'h1 -> captured word 80'h1, 81 ltc_out transitions, frame_done once, enc_frames=5 afterwards.
REQ-032 Wrap, FPS=25: preset 15:59:59:24, one frame -> enc_* = 0:0:0:0 after frame_done.
REQ-033 Out-of-range preset 00:61:75:30 with FPS=25 -> enc_minutes=0, enc_seconds=0, enc_frames=0.
REQ-034 Drop run at bit 40 -> frame completes at 80 bits, single frame_done, then busy=0 and preset_ready=1.
REQ-035 preset_valid=1 held while busy -> preset_ready=0 and no change until IDLE; accepted on the first IDLE cycle; simultaneous run delays LOAD by one cycle.
